vfilter_ntap: RTL and testbench

- Parametrised successor of the 3-tap vertical filter stage: an N-tap vertical FIR over one column of pixels from the line buffers.
- Unsigned pixels, signed fixed-point coefficients, round-half-up, clamp to pixel range.
- Full valid/ready handshake with backpressure. Feeds the horizontal filter stage, with the centre tap forwarded in alignment alongside the result.

---
 rtl/vfilter_pkg.sv | 33 +++
 rtl/vfilter_round_clamp.sv | 34 +++
 rtl/vfilter_ntap.sv | 172 +++++++++++++++++
 tb/tb_vfilter_ntap.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfilter_pkg.sv
// Shared definitions for the vertical N-tap filter and its reusable
// round/clamp stage: default parameters, width helpers and the
// identity-coefficient generator.
package vfilter_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_TAP_NUMS    = 3;
   localparam int DEF_COEFF_WIDTH = 14;
   localparam int DEF_FRAC_BITS   = 12;

   // Upper bounds used to size the identity-coefficient constant vector.
   localparam int MAX_TAP_NUMS    = 9;
   localparam int MAX_COEFF_WIDTH = 32;
   localparam int IDENT_VEC_W     = MAX_TAP_NUMS * MAX_COEFF_WIDTH;

   // Zero-extended pixel (one extra sign bit) times a signed coefficient.
   function automatic int prod_width(input int dw, input int cw);
      return dw + cw + 1;
   endfunction

   // Sum of all taps; the extra $clog2 bits make overflow impossible.
   function automatic int sum_width(input int dw, input int cw, input int taps);
      return prod_width(dw, cw) + $clog2(taps);
   endfunction

   // Packed coefficient vector with 1.0 on the centre tap and 0 elsewhere.
   function automatic logic [IDENT_VEC_W-1:0] identity_coeffs(input int taps,
                                                              input int cw,
                                                              input int frac);
      return IDENT_VEC_W'(1) << ((taps / 2) * cw + frac);
   endfunction

endpackage

// File: rtl/vfilter_round_clamp.sv
// Combinational round-half-up followed by saturation to the unsigned
// pixel range. Shared by the vertical and horizontal filter stages.
module vfilter_round_clamp #(
   parameter int IN_WIDTH   = 25,
   parameter int FRAC_BITS  = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic signed [IN_WIDTH-1:0] sum,
   output logic [DATA_WIDTH-1:0]      pix
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int EW = IN_WIDTH + 1;
   localparam logic signed [EW-1:0] HALF = EW'(1) <<< (FRAC_BITS - 1);

   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] rnd;
   logic signed [EW-1:0] shf;

   // Round half up, then clamp: negative -> 0, above full scale -> all ones.
   always_comb begin
      ext = {sum[IN_WIDTH-1], sum};
      rnd = ext + HALF;
      shf = rnd >>> FRAC_BITS;
      if (shf[EW-1]) begin
         pix = '0;
      end else if (|shf[EW-2:DATA_WIDTH]) begin
         pix = '1;
      end else begin
         pix = shf[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/vfilter_ntap.sv
// N-tap vertical FIR over one pixel column. Four pipeline stages:
// S0 capture, S1 per-tap products, S2 sum, S3 round/clamp register.
// The centre tap travels alongside and leaves aligned with the result.
// Optional build macro VFILTER_COEFF_SHADOW_EN adds coeff_load_i and a
// coefficient shadow register that resets to the identity filter.
module vfilter_ntap
   import vfilter_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int TAP_NUMS    = DEF_TAP_NUMS,
   parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
   parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
   input  logic                            clk,
   input  logic                            rst,
`ifdef VFILTER_COEFF_SHADOW_EN
   input  logic                            coeff_load_i,
`endif
   input  logic                            valid_i,
   output logic                            ready_o,
   input  logic [TAP_NUMS*DATA_WIDTH-1:0]  data_i,
   input  logic [TAP_NUMS*COEFF_WIDTH-1:0] coeff_i,
   output logic                            valid_o,
   input  logic                            ready_i,
   output logic [DATA_WIDTH-1:0]           data_o,
   output logic [DATA_WIDTH-1:0]           center_o
);

   localparam int PW     = prod_width(DATA_WIDTH, COEFF_WIDTH);
   localparam int SW     = sum_width(DATA_WIDTH, COEFF_WIDTH, TAP_NUMS);
   localparam int CENTER = TAP_NUMS / 2;
   localparam int DVW    = TAP_NUMS * DATA_WIDTH;
   localparam int CVW    = TAP_NUMS * COEFF_WIDTH;

   // Handshake: a column enters when valid_i & ready_o and a result leaves
   // when valid_o & ready_i. The whole pipe advances together on
   // en = ~valid_o | ready_i; with en low every stage register and valid
   // holds, so outputs are stable under backpressure and nothing is lost,
   // duplicated or reordered. ready_o is en, combinational from ready_i.
   logic en;
   assign en      = ~valid_o | ready_i;
   assign ready_o = en;

   logic                     s0_valid;
   logic [DVW-1:0]           s0_data;
   logic [CVW-1:0]           s1_coeff;

   logic                     s1_valid;
   logic signed [PW-1:0]     s1_prod [TAP_NUMS];
   logic [DATA_WIDTH-1:0]    s1_center;
   logic signed [PW-1:0]     prod_c [TAP_NUMS];

   logic                     s2_valid;
   logic signed [SW-1:0]     s2_sum;
   logic [DATA_WIDTH-1:0]    s2_center;
   logic signed [SW-1:0]     sum_c;

   logic [DATA_WIDTH-1:0]    rc_pix;

   // S0: capture the incoming column (valid 0 inserts a bubble).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_data  <= '0;
      end else if (en) begin
         s0_valid <= valid_i;
         s0_data  <= data_i;
      end
   end

`ifdef VFILTER_COEFF_SHADOW_EN
   localparam logic [IDENT_VEC_W-1:0] IDENT_FULL =
      identity_coeffs(TAP_NUMS, COEFF_WIDTH, FRAC_BITS);
   localparam logic [CVW-1:0] IDENT = IDENT_FULL[CVW-1:0];

   logic [CVW-1:0] shadow;
   logic [CVW-1:0] s0_coeff;

   // Shadow load runs regardless of pipeline enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= IDENT;
      end else if (coeff_load_i) begin
         shadow <= coeff_i;
      end
   end

   // Snapshot the shadow with each column so a load on the accept cycle
   // only affects columns accepted afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_coeff <= IDENT;
      end else if (en) begin
         s0_coeff <= shadow;
      end
   end

   assign s1_coeff = s0_coeff;
`else
   assign s1_coeff = coeff_i;
`endif

   // Per-tap product: zero-extended pixel times signed coefficient.
   for (genvar k = 0; k < TAP_NUMS; k++) begin : g_tap
      logic signed [PW-1:0] pix_x;
      logic signed [PW-1:0] coef_x;
      assign pix_x     = signed'(PW'(s0_data[k*DATA_WIDTH +: DATA_WIDTH]));
      assign coef_x    = PW'($signed(s1_coeff[k*COEFF_WIDTH +: COEFF_WIDTH]));
      assign prod_c[k] = pix_x * coef_x;
   end

   // S1: register products and the centre pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_center <= '0;
         for (int k = 0; k < TAP_NUMS; k++) begin
            s1_prod[k] <= '0;
         end
      end else if (en) begin
         s1_valid  <= s0_valid;
         s1_center <= s0_data[CENTER*DATA_WIDTH +: DATA_WIDTH];
         for (int k = 0; k < TAP_NUMS; k++) begin
            s1_prod[k] <= prod_c[k];
         end
      end
   end

   // Sign-extended sum of all products.
   always_comb begin
      sum_c = '0;
      for (int k = 0; k < TAP_NUMS; k++) begin
         sum_c = sum_c + SW'(s1_prod[k]);
      end
   end

   // S2: register the sum and centre pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_sum    <= '0;
         s2_center <= '0;
      end else if (en) begin
         s2_valid  <= s1_valid;
         s2_sum    <= sum_c;
         s2_center <= s1_center;
      end
   end

   vfilter_round_clamp #(
      .IN_WIDTH   (SW),
      .FRAC_BITS  (FRAC_BITS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_round_clamp (
      .sum (s2_sum),
      .pix (rc_pix)
   );

   // S3: output register for the rounded, clamped pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o  <= 1'b0;
         data_o   <= '0;
         center_o <= '0;
      end else if (en) begin
         valid_o  <= s2_valid;
         data_o   <= rc_pix;
         center_o <= s2_center;
      end
   end

endmodule

// File: tb/tb_vfilter_ntap.sv
// Self-checking bench for vfilter_ntap at default parameters. Also covers
// the coefficient shadow when built with VFILTER_COEFF_SHADOW_EN.
module tb_vfilter_ntap;

   localparam int DW     = 8;
   localparam int T      = 3;
   localparam int CW     = 14;
   localparam int F      = 12;
   localparam int CENTER = T / 2;
   localparam int DVW    = T * DW;
   localparam int CVW    = T * CW;

   logic           clk;
   logic           rst;
   logic           coeff_load_i;
   logic           valid_i;
   logic           ready_o;
   logic [DVW-1:0] data_i;
   logic [CVW-1:0] coeff_i;
   logic           valid_o;
   logic           ready_i;
   logic [DW-1:0]  data_o;
   logic [DW-1:0]  center_o;

   vfilter_ntap #(
      .DATA_WIDTH  (DW),
      .TAP_NUMS    (T),
      .COEFF_WIDTH (CW),
      .FRAC_BITS   (F)
   ) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef VFILTER_COEFF_SHADOW_EN
      .coeff_load_i (coeff_load_i),
`endif
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .data_i       (data_i),
      .coeff_i      (coeff_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .data_o       (data_o),
      .center_o     (center_o)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard state
   logic [2*DW-1:0] exp_q[$];
   int              acc_q[$];
   logic [CVW-1:0]  cur_coeff;
   int              n_checks;
   int              n_fail;
   int              cyc;
   bit              lat_chk;
   bit              hold_pend;
   logic [2*DW-1:0] held;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [DVW-1:0] cols(input int a, input int b, input int c);
      logic [DW-1:0] pa, pb, pc;
      pa = DW'(a); pb = DW'(b); pc = DW'(c);
      return {pc, pb, pa};
   endfunction

   function automatic logic [CVW-1:0] coefs(input int a, input int b, input int c);
      logic [CW-1:0] ca, cb, cc;
      ca = CW'(a); cb = CW'(b); cc = CW'(c);
      return {cc, cb, ca};
   endfunction

   // Reference filter: exact integer dot product, floor((x + 0.5)), clamp.
   function automatic logic [DW-1:0] model(input logic [DVW-1:0] d, input logic [CVW-1:0] c);
      longint        acc;
      logic [DW-1:0] px;
      logic signed [CW-1:0] cs;
      acc = 0;
      for (int k = 0; k < T; k++) begin
         px  = d[k*DW +: DW];
         cs  = c[k*CW +: CW];
         acc = acc + longint'(px) * longint'(cs);
      end
      acc = (acc + (longint'(1) << (F - 1))) >>> F;
      if (acc < 0) return '0;
      if (acc > longint'((1 << DW) - 1)) return '1;
      return acc[DW-1:0];
   endfunction

   // Output side: hold stability, scoreboard pop, optional latency.
   task automatic observe();
      logic [2*DW-1:0] e;
      int              a;
      if (hold_pend) begin
         check("hold_valid", 32'(valid_o), 32'd1);
         check("hold_data", 32'({center_o, data_o}), 32'(held));
      end
      if (valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            check("out_without_input", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("data_o", 32'(data_o), 32'(e[DW-1:0]));
            check("center_o", 32'(center_o), 32'(e[2*DW-1:DW]));
            if (lat_chk) check("latency", 32'(cyc - a), 32'd3);
         end
      end
      hold_pend = valid_o && !ready_i;
      held      = {center_o, data_o};
   endtask

   // One clock cycle of stimulus, checked just after inputs settle.
   task automatic cycle(input logic v, input logic [DVW-1:0] d, input logic rdy,
                        input logic ld, output logic acc);
      valid_i      = v;
      data_i       = d;
      ready_i      = rdy;
      coeff_load_i = ld;
      #1;
      if (rdy) check("ready_o_free", 32'(ready_o), 32'd1);
      else if (valid_o) check("ready_o_stall", 32'(ready_o), 32'd0);
      observe();
      acc = v && ready_o;
      if (acc) begin
         exp_q.push_back({d[CENTER*DW +: DW], model(d, cur_coeff)});
         acc_q.push_back(cyc + 1);
      end
      if (ld) cur_coeff = coeff_i;
      @(posedge clk);
      cyc++;
      #1;
      coeff_load_i = 1'b0;
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, acc);
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Pipe must be empty before calling in the default build.
   task automatic set_coeffs(input logic [CVW-1:0] c);
      logic acc;
      coeff_i = c;
      cycle(1'b0, '0, 1'b1, 1'b1, acc);
   endtask

   task automatic send(input logic [DVW-1:0] d);
      logic acc;
      cycle(1'b1, d, 1'b1, 1'b0, acc);
      check("accepted", 32'(acc), 32'd1);
   endtask

   initial begin
      logic acc;
      int   idx;
      logic rdy;
      n_checks = 0; n_fail = 0; cyc = 0;
      lat_chk = 1'b0; hold_pend = 1'b0; held = '0;
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; coeff_load_i = 1'b0;
      data_i = '0;
      coeff_i   = coefs(0, 4096, 0);
      cur_coeff = coefs(0, 4096, 0);

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_o", 32'(valid_o), 32'd0);
      check("rst_data_o", 32'(data_o), 32'd0);
      check("rst_center_o", 32'(center_o), 32'd0);
      check("rst_ready_o", 32'(ready_o), 32'd1);
      rst = 1'b0;

      // Identity coefficients (also the shadow reset value), exact latency
      lat_chk = 1'b1;
      send(cols(10, 20, 30));
      send(cols(5, 99, 7));
      send(cols(255, 0, 255));
      drain();
      lat_chk = 1'b0;

`ifdef VFILTER_COEFF_SHADOW_EN
      // Load concurrent with an accept affects only later columns
      coeff_i = coefs(4096, 0, 0);
      cycle(1'b1, cols(10, 20, 30), 1'b1, 1'b1, acc);
      check("shadow_accept", 32'(acc), 32'd1);
      coeff_i = coefs(0, 0, 0);
      send(cols(10, 20, 30));
      drain();
`endif

      // Average
      set_coeffs(coefs(1365, 1366, 1365));
      send(cols(90, 90, 90));
      drain();
      // Half rounds up
      set_coeffs(coefs(0, 2048, 0));
      send(cols(0, 3, 0));
      send(cols(9, 1, 9));
      drain();
      // Saturation high
      set_coeffs(coefs(0, 8191, 0));
      send(cols(0, 200, 0));
      drain();
      // Negative clamps to zero
      set_coeffs(coefs(0, 14'h3000, 0));
      send(cols(0, 50, 0));
      drain();

      // Random coefficients and columns
      for (int r = 0; r < 4; r++) begin
         set_coeffs(coefs($urandom_range(0, 16383), $urandom_range(0, 16383),
                          $urandom_range(0, 16383)));
         for (int j = 0; j < 4; j++) begin
            send(cols($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255)));
         end
         drain();
      end

      // Backpressure: 8 columns with a 5-cycle stall mid-stream
      set_coeffs(coefs(1024, 2048, 1024));
      idx = 0;
      for (int t = 0; t < 60 && idx < 8; t++) begin
         rdy = !(t >= 5 && t < 10);
         cycle(1'b1, cols(idx + 1, 2 * (idx + 1), 3 * (idx + 1)), rdy, 1'b0, acc);
         if (acc) idx++;
      end
      check("bp_all_sent", 32'(idx), 32'd8);
      drain();

      // Reset with columns in flight
      set_coeffs(coefs(0, 4096, 0));
      for (int j = 0; j < 4; j++) send(cols(100 + j, 120 + j, 140 + j));
      check("pre_rst_valid", 32'(valid_o), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_valid_o", 32'(valid_o), 32'd0);
      check("midrst_data_o", 32'(data_o), 32'd0);
      check("midrst_center_o", 32'(center_o), 32'd0);
      exp_q.delete();
      acc_q.delete();
      hold_pend = 1'b0;
      repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, acc);
      rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
         cycle(1'b0, '0, 1'b1, 1'b0, acc);
         check("post_rst_idle", 32'(valid_o), 32'd0);
      end
      send(cols(7, 77, 200));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
